// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for the Pong datapath.
//
// Owns the two per-player miss counts shown on the life-bar displays. It also
// sequences each rally: IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER).
// The ball logic is gated through ball_enable and ball_reset.
//
// Parameters:
//   MAX_SCORE    miss count at which a player loses (1..7)
//   SERVE_FRAMES frames spent in SERVE before the ball is released
//   POINT_FRAMES frames spent in POINT after a goal
//
// Ports:
//   clk         system/pixel clock
//   rst         asynchronous active-high reset
//   frame_tick  one-cycle pulse per video frame
//   start       debounced, level-sensitive start request
//   goal_left   ball left via the left edge (player 0 missed)
//   goal_right  ball left via the right edge (player 1 missed)
//   score0      player 0 miss count
//   score1      player 1 miss count
//   ball_enable high only in PLAY
//   ball_reset  one-cycle pulse on the first cycle of SERVE
//   serve_dir   launch direction, 0 = toward left player, 1 = toward right player
//   game_over   high in OVER
//   winner      0 = player 0 won, 1 = player 1 won (valid with game_over)
//
// All outputs are registered.

module pong_match_ctrl #(
    parameter int unsigned MAX_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [2:0] score0,
    output logic [2:0] score1,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned CntMax = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);
    localparam logic [CntW-1:0] PointLast = CntW'(POINT_FRAMES - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [2:0]      ScoreMax  = 3'(MAX_SCORE);

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StPoint,
        StOver
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      score0_q, score0_d;
    logic [2:0]      score1_q, score1_d;
    logic            serve_dir_q, serve_dir_d;
    logic            winner_q, winner_d;
    logic            ball_enable_q, ball_enable_d;
    logic            ball_reset_q, ball_reset_d;
    logic            game_over_q, game_over_d;
    logic            start_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score0_d    = score0_q;
        score1_d    = score1_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;

        unique case (state_q)
            StIdle: begin
                score0_d = '0;
                score1_d = '0;
                if (start) begin
                    state_d = StServe;
                end
            end

            StServe: begin
                if (frame_tick) begin
                    if (cnt_q == ServeLast) begin
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StPlay: begin
                if (goal_left || goal_right) begin
                    state_d = StPoint;
                    // Both edges in one cycle is treated as a replay: nothing changes.
                    if (goal_left && !goal_right) begin
                        if (score0_q != ScoreMax) begin
                            score0_d = score0_q + 3'd1;
                        end
                        serve_dir_d = 1'b0;
                    end else if (goal_right && !goal_left) begin
                        if (score1_q != ScoreMax) begin
                            score1_d = score1_q + 3'd1;
                        end
                        serve_dir_d = 1'b1;
                    end
                end
            end

            StPoint: begin
                if (score0_q == ScoreMax || score1_q == ScoreMax) begin
                    state_d  = StOver;
                    // The player who reached the limit lost.
                    winner_d = (score0_q == ScoreMax);
                end else if (frame_tick) begin
                    if (cnt_q == PointLast) begin
                        state_d = StServe;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StOver: begin
                // Edge-detect so a start held through the end of a match is ignored.
                if (start && !start_q) begin
                    state_d     = StServe;
                    score0_d    = '0;
                    score1_d    = '0;
                    serve_dir_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A tick on the transition edge is not credited to the new state.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        ball_enable_d = (state_d == StPlay);
        game_over_d   = (state_d == StOver);
        ball_reset_d  = (state_d == StServe) && (state_q != StServe);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            score0_q      <= '0;
            score1_q      <= '0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            ball_enable_q <= 1'b0;
            ball_reset_q  <= 1'b0;
            game_over_q   <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            ball_enable_q <= ball_enable_d;
            ball_reset_q  <= ball_reset_d;
            game_over_q   <= game_over_d;
            start_q       <= start;
        end
    end

    assign score0      = score0_q;
    assign score1      = score1_q;
    assign ball_enable = ball_enable_q;
    assign ball_reset  = ball_reset_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: a short table of directed vectors,
// hand-written multi-cycle sequences, then randomized stimulus, all compared
// each cycle against a rally-level reference model.

module tb_pong_match_ctrl;

    localparam int unsigned MAX_SCORE    = 7;
    localparam int unsigned SERVE_FRAMES = 60;
    localparam int unsigned POINT_FRAMES = 30;

    localparam int PhIdle  = 0;
    localparam int PhServe = 1;
    localparam int PhPlay  = 2;
    localparam int PhPoint = 3;
    localparam int PhOver  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       goal_left = 1'b0;
    logic       goal_right = 1'b0;
    logic [2:0] score0;
    logic [2:0] score1;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    pong_match_ctrl #(
        .MAX_SCORE    (MAX_SCORE),
        .SERVE_FRAMES (SERVE_FRAMES),
        .POINT_FRAMES (POINT_FRAMES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start       (start),
        .goal_left   (goal_left),
        .goal_right  (goal_right),
        .score0      (score0),
        .score1      (score1),
        .ball_enable (ball_enable),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: match phase plus frames still to wait in it.
    int m_phase;
    int m_left;
    int m_s0;
    int m_s1;
    int m_dir;
    int m_win;
    int m_pulse;
    int m_prev_start;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PhIdle;
        m_left = 0;
        m_s0 = 0;
        m_s1 = 0;
        m_dir = 0;
        m_win = 0;
        m_pulse = 0;
        m_prev_start = 0;
    endtask

    task automatic begin_serve();
        m_phase = PhServe;
        m_left = SERVE_FRAMES;
        m_pulse = 1;
    endtask

    // One clock edge of the match rules, using the inputs as sampled.
    task automatic model_step();
        m_pulse = 0;
        case (m_phase)
            PhIdle: if (start) begin_serve();
            PhServe: if (frame_tick) begin
                m_left--;
                if (m_left == 0) m_phase = PhPlay;
            end
            PhPlay: if (goal_left || goal_right) begin
                if (goal_left && !goal_right) begin
                    m_s0 = (m_s0 + 1 > MAX_SCORE) ? MAX_SCORE : m_s0 + 1;
                    m_dir = 0;
                end else if (goal_right && !goal_left) begin
                    m_s1 = (m_s1 + 1 > MAX_SCORE) ? MAX_SCORE : m_s1 + 1;
                    m_dir = 1;
                end
                m_phase = PhPoint;
                m_left = POINT_FRAMES;
            end
            PhPoint: begin
                if (m_s0 == MAX_SCORE || m_s1 == MAX_SCORE) begin
                    m_phase = PhOver;
                    m_win = (m_s0 == MAX_SCORE) ? 1 : 0;
                end else if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) begin_serve();
                end
            end
            PhOver: if (start && m_prev_start == 0) begin
                m_s0 = 0;
                m_s1 = 0;
                m_dir = 0;
                begin_serve();
            end
            default: m_phase = PhIdle;
        endcase
        m_prev_start = start ? 1 : 0;
    endtask

    task automatic check_model();
        chk("score0", int'(score0), m_s0);
        chk("score1", int'(score1), m_s1);
        chk("ball_enable", int'(ball_enable), (m_phase == PhPlay) ? 1 : 0);
        chk("ball_reset", int'(ball_reset), m_pulse);
        chk("serve_dir", int'(serve_dir), m_dir);
        chk("game_over", int'(game_over), (m_phase == PhOver) ? 1 : 0);
        if (m_phase == PhOver) chk("winner", int'(winner), m_win);
    endtask

    task automatic step(input bit s, input bit t, input bit gl, input bit gr);
        start = s;
        frame_tick = t;
        goal_left = gl;
        goal_right = gr;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run_ticks(input int n, input bit s);
        for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_until_play(input bit s);
        int n;
        n = 0;
        while (!ball_enable && n < 500) begin
            step(s, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("reach_play", int'(ball_enable), 1);
    endtask

    // Called just after an edge; checks the outputs before the next edge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("rst_score0", int'(score0), 0);
        chk("rst_score1", int'(score1), 0);
        chk("rst_ball_enable", int'(ball_enable), 0);
        chk("rst_ball_reset", int'(ball_reset), 0);
        chk("rst_serve_dir", int'(serve_dir), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit s;
        bit t;
        bit gl;
        bit gr;
        int s0;
        int s1;
        bit be;
        bit br;
        bit dir;
        bit go;
    } vec_t;

    vec_t tbl[4];

    initial begin
        model_reset();
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        async_reset();

        // Idle, start, and the first SERVE cycles (one tick already counted).
        for (int i = 0; i < 4; i++) begin
            step(tbl[i].s, tbl[i].t, tbl[i].gl, tbl[i].gr);
            chk("tbl_score0", int'(score0), tbl[i].s0);
            chk("tbl_score1", int'(score1), tbl[i].s1);
            chk("tbl_ball_enable", int'(ball_enable), int'(tbl[i].be));
            chk("tbl_ball_reset", int'(ball_reset), int'(tbl[i].br));
            chk("tbl_serve_dir", int'(serve_dir), int'(tbl[i].dir));
            chk("tbl_game_over", int'(game_over), int'(tbl[i].go));
        end

        // Serve release after exactly SERVE_FRAMES ticks.
        run_ticks(SERVE_FRAMES - 2, 1'b0);
        chk("serve_hold", int'(ball_enable), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("serve_release", int'(ball_enable), 1);

        // Single goal and the point pause.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("goal_score0", int'(score0), 1);
        chk("goal_dir", int'(serve_dir), 0);
        chk("goal_be", int'(ball_enable), 0);
        run_ticks(POINT_FRAMES - 1, 1'b0);
        chk("point_hold", int'(ball_reset), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("point_reset", int'(ball_reset), 1);
        run_until_play(1'b0);

        // Right goal, then a simultaneous-goal replay keeps everything.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("right_dir", int'(serve_dir), 1);
        run_until_play(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("both_score0", int'(score0), 1);
        chk("both_score1", int'(score1), 1);
        chk("both_dir", int'(serve_dir), 1);
        chk("both_be", int'(ball_enable), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("point_spurious", int'(score0) + int'(score1), 2);
        run_until_play(1'b0);

        // Reach score0 = 3 in PLAY, then reset mid-rally.
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            run_until_play(1'b0);
        end
        chk("pre_rst_score0", int'(score0), 3);
        async_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_reset_pulse", int'(ball_reset), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_reset_once", int'(ball_reset), 0);
        run_until_play(1'b1);

        // Seven right-edge goals with start held high throughout.
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (k < 6) run_until_play(1'b1);
        end
        chk("final_score1", int'(score1), 7);
        chk("point_not_over", int'(game_over), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("over_flag", int'(game_over), 1);
        chk("over_winner", int'(winner), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("over_frozen0", int'(score0), 0);
        chk("over_frozen1", int'(score1), 7);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("held_start_no_restart", int'(game_over), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_start", int'(game_over), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_score1", int'(score1), 0);
        chk("restart_pulse", int'(ball_reset), 1);
        chk("restart_over", int'(game_over), 0);

        // Randomized stimulus against the model, with occasional resets.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 4999) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
